mem_arbiter: RTL

Two-port-to-one memory arbiter between the rv32e_core instruction-fetch port and its load/store port and a single shared, variable-latency memory port (unified SRAM/flash controller). It grants one access at a time, registers the winning address, data and direction, and waits for the memory handshake. It returns a one-cycle ready pulse with read data to the winning requester. A watchdog aborts accesses whose memory never answers.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_wdog.sv | 41 ++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Identity of the requester that owns (or last owned) the memory port.
  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_e;

  // Default watchdog limit in BUSY cycles without m_ready; 0 disables it.
  localparam int unsigned DEFAULT_TIMEOUT = 32'd255;

endpackage

// File: rtl/mem_arbiter_wdog.sv
// Watchdog counter: counts stalled BUSY cycles and flags expiry at TIMEOUT.
module mem_arbiter_wdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  // A zero TIMEOUT still needs a one-bit counter to stay legal.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_q, count_d;

  // Expiry is a pure compare so m_ready in the same cycle can still win.
  assign expire_o = (TIMEOUT != 0) && (count_q == CW'(TIMEOUT));

  // Next count: clear outside BUSY, advance on each stalled cycle, hold at the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expire_o) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto one variable-latency memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_re_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              m_valid_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic              m_ready_i,
  output logic              err_o
);

  state_e            state_q;
  grant_e            grant_q, last_grant_q, grant_d;
  logic              m_valid_q, m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, if_rdata_q, d_rdata_q;
  logic              if_ready_q, d_ready_q, err_q;
  logic              data_req, any_req, wdog_expire;

  assign data_req = d_re_i | d_we_i;
  assign any_req  = if_req_i | data_req;

  // Pick the next owner: a lone requester wins, contention alternates starting with data.
  always_comb begin
    grant_d = FETCH;
    if (data_req && (!if_req_i || (last_grant_q != DATA))) begin
      grant_d = DATA;
    end
  end

  mem_arbiter_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != BUSY),
    .en_i     ((state_q == BUSY) && !m_ready_i),
    .expire_o (wdog_expire)
  );

  // Arbiter FSM with all memory-side and requester-side outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= FETCH;
      last_grant_q <= FETCH;
      m_valid_q    <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q   <= grant_d;
            m_valid_q <= 1'b1;
            m_we_q    <= (grant_d == DATA) ? d_we_i : 1'b0;
            m_addr_q  <= (grant_d == DATA) ? d_addr_i : if_addr_i;
            m_wdata_q <= (grant_d == DATA) ? d_wdata_i : '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= RESP;
            if (grant_q == DATA) begin
              d_rdata_q <= m_we_q ? '0 : m_rdata_i;
              d_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= m_rdata_i;
              if_ready_q <= 1'b1;
            end
          end else if (wdog_expire) begin
            m_valid_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= RESP;
            if (grant_q == DATA) begin
              d_rdata_q <= '0;
              d_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= '0;
              if_ready_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if_ready_q   <= 1'b0;
          d_ready_q    <= 1'b0;
          err_q        <= 1'b0;
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_valid_o  = m_valid_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign if_rdata_o = if_rdata_q;
  assign if_ready_o = if_ready_q;
  assign d_rdata_o  = d_rdata_q;
  assign d_ready_o  = d_ready_q;
  assign err_o      = err_q;

endmodule
